// File: rtl/io_merge_align.sv
// io_merge_align
// Recombines a complementary pad pair (din_p/din_n) into one qualified,
// clock-aligned data bit. Each leg is synchronized separately. The pair is then
// classified as V1 (1,0), V0 (0,1) or INV (p==n). A run of FILT_CYC identical
// valid samples is needed before dout changes. A run of ERR_CYC INV samples
// while locked raises a sticky pair fault.
//
// Ports:
//   clk       sampling clock
//   reset     asynchronous, active-high reset
//   din_p     positive leg, asynchronous to clk
//   din_n     negative leg, asynchronous to clk
//   en        receiver enable; low returns to WAIT and holds dout
//   err_clr   single-cycle pulse that leaves FAULT
//   dout      recombined single-ended data
//   dout_vld  high while dout is qualified (LOCK)
//   pair_err  sticky pair-integrity fault
//   edge_cnt  count of dout transitions in LOCK (wraps)
module io_merge_align #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int ERR_CYC     = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_p,
    input  logic             din_n,
    input  logic             en,
    input  logic             err_clr,
    output logic             dout,
    output logic             dout_vld,
    output logic             pair_err,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int FILT_W = $clog2(FILT_CYC + 1);
    localparam int ERR_W  = $clog2(ERR_CYC + 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // The synchronizers reset to the V0 pattern. An idle pad is therefore
    // seen as a valid 0 rather than as an INV pair.
    logic [SYNC_STAGES-1:0] sync_p_reg;
    logic [SYNC_STAGES-1:0] sync_n_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p_reg <= '0;
            sync_n_reg <= '1;
        end else begin
            sync_p_reg <= {sync_p_reg[SYNC_STAGES-2:0], din_p};
            sync_n_reg <= {sync_n_reg[SYNC_STAGES-2:0], din_n};
        end
    end

    logic sample_p;
    logic sample_n;
    logic sample_valid;

    assign sample_p     = sync_p_reg[SYNC_STAGES-1];
    assign sample_n     = sync_n_reg[SYNC_STAGES-1];
    assign sample_valid = sample_p ^ sample_n;

    state_t            state_reg, state_next;
    logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
    logic [ERR_W-1:0]  inv_cnt_reg, inv_cnt_next;
    logic              cand_reg, cand_next;
    logic              dout_reg, dout_next;
    logic              dout_vld_reg, dout_vld_next;
    logic              pair_err_reg, pair_err_next;
    logic [CNT_W-1:0]  edge_cnt_reg, edge_cnt_next;

    logic [FILT_W-1:0] run_len;
    logic [ERR_W-1:0]  inv_run;

    always_comb begin
        state_next    = state_reg;
        filt_cnt_next = filt_cnt_reg;
        inv_cnt_next  = inv_cnt_reg;
        cand_next     = cand_reg;
        dout_next     = dout_reg;
        dout_vld_next = dout_vld_reg;
        pair_err_next = pair_err_reg;
        edge_cnt_next = edge_cnt_reg;
        run_len       = FILT_W'(1);
        // The INV run saturates at ERR_CYC. Outside LOCK it has no effect,
        // and the next valid sample clears it anyway.
        inv_run       = (inv_cnt_reg == ERR_W'(ERR_CYC)) ? inv_cnt_reg
                                                         : inv_cnt_reg + 1'b1;

        case (state_reg)
            ST_FAULT: begin
                filt_cnt_next = '0;
                inv_cnt_next  = '0;
                if (err_clr) begin
                    state_next    = ST_WAIT;
                    pair_err_next = 1'b0;
                end
            end

            ST_WAIT, ST_LOCK: begin
                if (!en) begin
                    state_next    = ST_WAIT;
                    dout_vld_next = 1'b0;
                    filt_cnt_next = '0;
                    inv_cnt_next  = '0;
                end else if (!sample_valid) begin
                    filt_cnt_next = '0;
                    inv_cnt_next  = inv_run;
                    // Fault entry takes priority. err_clr is not examined
                    // outside FAULT.
                    if (state_reg == ST_LOCK && inv_run == ERR_W'(ERR_CYC)) begin
                        state_next    = ST_FAULT;
                        pair_err_next = 1'b1;
                        dout_vld_next = 1'b0;
                        inv_cnt_next  = '0;
                    end
                end else begin
                    inv_cnt_next = '0;
                    if (state_reg == ST_WAIT) begin
                        // A valid sample that differs from the current
                        // candidate starts a new run at length 1.
                        if (filt_cnt_reg != '0 && sample_p == cand_reg)
                            run_len = filt_cnt_reg + 1'b1;
                        if (run_len == FILT_W'(FILT_CYC)) begin
                            state_next    = ST_LOCK;
                            dout_next     = sample_p;
                            dout_vld_next = 1'b1;
                            filt_cnt_next = '0;
                        end else begin
                            filt_cnt_next = run_len;
                            cand_next     = sample_p;
                        end
                    end else begin
                        // In LOCK, only samples opposite to dout build a run.
                        if (sample_p == dout_reg) begin
                            filt_cnt_next = '0;
                        end else begin
                            run_len = filt_cnt_reg + 1'b1;
                            if (run_len == FILT_W'(FILT_CYC)) begin
                                dout_next     = ~dout_reg;
                                edge_cnt_next = edge_cnt_reg + 1'b1;
                                filt_cnt_next = '0;
                            end else begin
                                filt_cnt_next = run_len;
                            end
                        end
                    end
                end
            end

            default: begin
                state_next    = ST_WAIT;
                dout_vld_next = 1'b0;
                filt_cnt_next = '0;
                inv_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_WAIT;
            filt_cnt_reg <= '0;
            inv_cnt_reg  <= '0;
            cand_reg     <= 1'b0;
            dout_reg     <= 1'b0;
            dout_vld_reg <= 1'b0;
            pair_err_reg <= 1'b0;
            edge_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            filt_cnt_reg <= filt_cnt_next;
            inv_cnt_reg  <= inv_cnt_next;
            cand_reg     <= cand_next;
            dout_reg     <= dout_next;
            dout_vld_reg <= dout_vld_next;
            pair_err_reg <= pair_err_next;
            edge_cnt_reg <= edge_cnt_next;
        end
    end

    assign dout     = dout_reg;
    assign dout_vld = dout_vld_reg;
    assign pair_err = pair_err_reg;
    assign edge_cnt = edge_cnt_reg;

endmodule

// File: tb/tb_io_merge_align.sv
// Testbench for io_merge_align. It runs a directed walk through the main
// scenarios, then randomized pair segments. Each cycle is compared against a
// behavioural model. That model keeps the history of classified samples since
// the last event and measures trailing runs directly.
module tb_io_merge_align;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYC    = 3;
    localparam int ERR_CYC     = 4;
    localparam int CNT_W       = 4;

    logic             clk;
    logic             reset;
    logic             din_p;
    logic             din_n;
    logic             en;
    logic             err_clr;
    logic             dout;
    logic             dout_vld;
    logic             pair_err;
    logic [CNT_W-1:0] edge_cnt;

    io_merge_align #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYC   (FILT_CYC),
        .ERR_CYC    (ERR_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din_p   (din_p),
        .din_n   (din_n),
        .en      (en),
        .err_clr (err_clr),
        .dout    (dout),
        .dout_vld(dout_vld),
        .pair_err(pair_err),
        .edge_cnt(edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural reference: classes are 0 (V0), 1 (V1), 2 (INV).
    // States are 0 (WAIT), 1 (LOCK), 2 (FAULT).
    int m_pipe_p[$];
    int m_pipe_n[$];
    int m_hist[$];
    int m_state, m_dout, m_vld, m_perr, m_edges;

    task automatic model_reset();
        m_pipe_p.delete();
        m_pipe_n.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_pipe_p.push_back(0);
            m_pipe_n.push_back(1);
        end
        m_hist.delete();
        m_state = 0;
        m_dout  = 0;
        m_vld   = 0;
        m_perr  = 0;
        m_edges = 0;
    endtask

    task automatic model_step();
        int sp, sn, cls, k;
        sp = m_pipe_p.pop_front();
        sn = m_pipe_n.pop_front();
        m_pipe_p.push_back(int'(din_p));
        m_pipe_n.push_back(int'(din_n));
        cls = (sp != sn) ? sp : 2;
        if (m_state == 2) begin
            if (err_clr) begin
                m_state = 0;
                m_perr  = 0;
                m_hist.delete();
            end
            return;
        end
        if (!en) begin
            m_state = 0;
            m_vld   = 0;
            m_hist.delete();
            return;
        end
        m_hist.push_back(cls);
        if (m_hist.size() > 16) void'(m_hist.pop_front());
        k = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != cls) break;
            k++;
        end
        if (cls == 2) begin
            if (m_state == 1 && k >= ERR_CYC) begin
                m_state = 2;
                m_perr  = 1;
                m_vld   = 0;
                m_hist.delete();
            end
        end else if (m_state == 0) begin
            if (k >= FILT_CYC) begin
                m_state = 1;
                m_dout  = cls;
                m_vld   = 1;
                m_hist.delete();
            end
        end else if (cls != m_dout && k >= FILT_CYC) begin
            m_dout  = cls;
            m_edges = (m_edges + 1) % (1 << CNT_W);
            m_hist.delete();
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check_model();
        check_val("mdl_dout", dout, m_dout);
        check_val("mdl_vld", dout_vld, m_vld);
        check_val("mdl_perr", pair_err, m_perr);
        check_val("mdl_edges", edge_cnt, m_edges);
    endtask

    // Applies one input pattern for a number of cycles. Each cycle is checked
    // on the falling edge.
    task automatic drive(input logic p, input logic n, input logic e, input logic c, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            din_p   = p;
            din_n   = n;
            en      = e;
            err_clr = c;
            @(posedge clk);
            @(negedge clk);
            err_clr = 1'b0;
            check_model();
        end
    endtask

    // Asserts reset between clock edges and checks that the outputs have
    // cleared before any edge arrives.
    task automatic async_reset_check();
        #2 reset = 1'b1;
        #1;
        check_val("arst_dout", dout, 0);
        check_val("arst_vld", dout_vld, 0);
        check_val("arst_perr", pair_err, 0);
        check_val("arst_edges", edge_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Releases into a steady V1 input and checks the qualification latency.
    task automatic recover();
        drive(1'b1, 1'b0, 1'b1, 1'b0, SYNC_STAGES + FILT_CYC - 1);
        check_val("lat_vld_early", dout_vld, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1);
        check_val("lat_vld", dout_vld, 1);
        check_val("lat_dout", dout, 1);
        check_val("lat_edges", edge_cnt, 0);
        check_val("lat_perr", pair_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic v;
        int   cls_sel, hold;
        logic rp, rn, re;
        model_reset();
        reset   = 1'b1;
        din_p   = 1'b1;
        din_n   = 1'b0;
        en      = 1'b1;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_dout", dout, 0);
        check_val("rst_vld", dout_vld, 0);
        check_val("rst_perr", pair_err, 0);
        check_val("rst_edges", edge_cnt, 0);
        reset = 1'b0;

        $display("[TB] step: qualify after reset");
        recover();

        $display("[TB] step: short glitch rejected");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5);
        check_val("glitch_dout", dout, 1);
        check_val("glitch_edges", edge_cnt, 0);

        $display("[TB] step: filtered transition to 0");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4);
        check_val("xfer_early", dout, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
        check_val("xfer_dout", dout, 0);
        check_val("xfer_edges", edge_cnt, 1);

        $display("[TB] step: short INV run tolerated");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4);
        check_val("inv3_perr", pair_err, 0);
        check_val("inv3_vld", dout_vld, 1);
        check_val("inv3_dout", dout, 0);

        $display("[TB] step: persistent INV faults");
        drive(1'b0, 1'b0, 1'b1, 1'b0, SYNC_STAGES + ERR_CYC - 1);
        check_val("inv_pre_perr", pair_err, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
        check_val("fault_perr", pair_err, 1);
        check_val("fault_vld", dout_vld, 0);
        check_val("fault_dout", dout, 0);

        $display("[TB] step: clear fault and requalify");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3);
        check_val("fault_sticky", pair_err, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1);
        check_val("clr_perr", pair_err, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, FILT_CYC - 1);
        check_val("clr_vld_early", dout_vld, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1);
        check_val("clr_vld", dout_vld, 1);
        check_val("clr_dout", dout, 1);
        check_val("clr_edges", edge_cnt, 1);

        $display("[TB] step: err_clr ignored in LOCK");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1);
        check_val("lockclr_vld", dout_vld, 1);
        check_val("lockclr_perr", pair_err, 0);

        $display("[TB] step: async reset mid-filter");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4);
        check_val("midfilt_dout", dout, 1);
        async_reset_check();
        recover();

        $display("[TB] step: async reset mid-fault");
        drive(1'b0, 1'b0, 1'b1, 1'b0, SYNC_STAGES + ERR_CYC);
        check_val("midfault_perr", pair_err, 1);
        async_reset_check();
        recover();

        $display("[TB] step: edge counter wrap");
        for (int t = 0; t < 16; t++) begin
            v = (t % 2 == 0) ? 1'b0 : 1'b1;
            drive(v, ~v, 1'b1, 1'b0, 5);
            if (t == 14) check_val("wrap_15", edge_cnt, 15);
        end
        check_val("wrap_0", edge_cnt, 0);
        check_val("wrap_dout", dout, 1);

        $display("[TB] step: enable drop and requalify");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        check_val("en_drop_vld", dout_vld, 0);
        check_val("en_drop_dout", dout, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, FILT_CYC - 1);
        check_val("en_req_early", dout_vld, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1);
        check_val("en_req_vld", dout_vld, 1);

        $display("[TB] step: randomized segments");
        for (int seg = 0; seg < 200; seg++) begin
            cls_sel = $urandom_range(0, 9);
            if (cls_sel < 4)      begin rp = 1'b1; rn = 1'b0; end
            else if (cls_sel < 8) begin rp = 1'b0; rn = 1'b1; end
            else begin rp = 1'($urandom_range(0, 1)); rn = rp; end
            hold = $urandom_range(1, 6);
            re   = ($urandom_range(0, 29) != 0);
            for (int c = 0; c < hold; c++)
                drive(rp, rn, re, ($urandom_range(0, 11) == 0), 1);
            if (seg % 67 == 66) async_reset_check();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
